// File: rtl/uart_stream_phy.sv
// 8N1 async serial endpoint with valid/ready byte ports on both sides.
// TX serializes accepted bytes onto txd; RX deserializes rxd into a one-entry holding register.
module uart_stream_phy #(
    parameter int DIVISOR = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_val,
    output logic       in_rdy,
    output logic [7:0] out_data,
    output logic       out_val,
    input  logic       out_rdy,
    output logic       txd,
    input  logic       rxd,
    output logic       frame_err,
    output logic       overrun
);
    // Handshake: a byte moves on the rising edge where val && rdy; the producer
    // holds val and data stable until then.
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t       tx_state, tx_next;
    logic [9:0]      tx_shreg;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;
    logic            tx_load;
    logic            tx_bit_end;
    logic            tx_q;

    rx_state_t       rx_state, rx_next;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shreg;
    logic            rx_tick;
    logic            rx_deliver;
    logic            rx_ferr;

    assign in_rdy = (tx_state == TX_IDLE);
    assign txd    = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        tx_next    = tx_state;
        tx_load    = 1'b0;
        tx_bit_end = (tx_cnt == BIT_LAST);
        case (tx_state)
            TX_IDLE: begin
                if (in_val) begin
                    tx_load = 1'b1;
                    tx_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_bit_end && tx_bit == 4'd9) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // txd is registered so the start bit appears one edge after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q     <= 1'b1;
            tx_shreg <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            tx_q <= (tx_state == TX_SHIFT) ? tx_shreg[0] : 1'b1;
            if (tx_load) begin
                tx_shreg <= {1'b1, in_data, 1'b0};
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state == TX_SHIFT) begin
                if (tx_bit_end) begin
                    tx_cnt   <= '0;
                    tx_shreg <= {1'b1, tx_shreg[9:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_deliver = 1'b0;
        rx_ferr    = 1'b0;
        rx_tick    = (rx_cnt == '0);
        case (rx_state)
            RX_IDLE:  if (!rxs) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_tick) begin
                    if (rxs) begin
                        rx_deliver = 1'b1;
                        rx_next    = RX_IDLE;
                    end else begin
                        rx_ferr = 1'b1;
                        rx_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: if (rxs) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    // The down counter is parked at a half bit while idle so the start bit is
    // re-checked at its centre; later samples are a full bit apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shreg  <= '0;
            out_data  <= '0;
            out_val   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rxs       <= rx_meta;
            frame_err <= rx_ferr;
            overrun   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= HALF_LAST;
                    rx_bit <= '0;
                end
                RX_START, RX_STOP: rx_cnt <= rx_tick ? BIT_LAST : rx_cnt - 1'b1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= BIT_LAST;
                        rx_shreg <= {rxs, rx_shreg[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_cnt <= HALF_LAST;
            endcase
            // A byte arriving while the held byte is being consumed replaces it.
            if (rx_deliver) begin
                if (!out_val || out_rdy) begin
                    out_data <= rx_shreg;
                    out_val  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_rdy) begin
                out_val <= 1'b0;
            end
        end
    end
endmodule
